// File: rtl/mem_lsu_stage_if.sv
// Split-transaction data-SRAM bus between the memory-access stage (master)
// and the data memory (slave). Signal names are seen from the stage's side.
interface mem_lsu_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  data_req_o;
  logic                  data_wr_o;
  logic [DATA_W/8-1:0]   data_wstrb_o;
  logic [ADDR_W-1:0]     data_addr_o;
  logic [DATA_W-1:0]     data_wdata_o;
  logic                  data_addr_ok_i;
  logic                  data_data_ok_i;
  logic [DATA_W-1:0]     data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: issues one load/store at a time on the split-transaction
// data bus, aligns and extends load data, and holds the result while WB stalls.
module mem_lsu_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid_i,
  input  logic                wb_allowin_i,
  input  logic                flush_i,
  output logic                mem_allowin_o,
  output logic                mem_to_wb_valid_o,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [1:0]          size_i,
  input  logic                sign_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                regs_we_i,
  input  logic [RADDR_W-1:0]  regs_waddr_i,
  input  logic [DATA_W-1:0]   regs_wdata_i,
  mem_lsu_stage_if.master     dmem,
  output logic                regs_we_o,
  output logic [RADDR_W-1:0]  regs_waddr_o,
  output logic [DATA_W-1:0]   regs_wdata_o,
  output logic                ale_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_CANCEL} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic [OFF-1:0]      offset;
  logic                misaligned;
  logic                aligned_access;
  logic                ready_go;
  logic                data_req;
  int                  nbytes;
  int                  nbits;
  logic                sign_bit;
  logic [STRB_W-1:0]   size_mask;
  logic [DATA_W-1:0]   wdata_rep;
  logic [DATA_W-1:0]   rdata_sh;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   result;

  assign offset = addr_i[OFF-1:0];

  // A dword access can never be aligned on a 32-bit datapath.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    misaligned = 1'b0;
    case (size_i)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = addr_i[0];
      2'd2: misaligned = |addr_i[1:0];
      2'd3: misaligned = (DATA_W == 32) || (|addr_i[2:0]);
    endcase
  end

  assign aligned_access = req_i & ~misaligned;

  always_comb begin
    nbytes    = 1 << size_i;
    nbits     = (8 * nbytes > DATA_W) ? DATA_W : 8 * nbytes;
    size_mask = '0;
    wdata_rep = '0;
    for (int i = 0; i < STRB_W; i++) begin
      size_mask[i]       = (i < nbytes);
      wdata_rep[8*i +: 8] = wdata_i[8*(i % nbytes) +: 8];
    end
    rdata_sh = dmem.data_rdata_i >> {offset, 3'b000};
    sign_bit = 1'b0;
    case (size_i)
      2'd0: sign_bit = sign_i & rdata_sh[7];
      2'd1: sign_bit = sign_i & rdata_sh[15];
      2'd2: sign_bit = sign_i & rdata_sh[31];
      2'd3: sign_bit = sign_i & rdata_sh[DATA_W-1];
    endcase
    for (int b = 0; b < DATA_W; b++) begin
      load_ext[b] = (b < nbits) ? rdata_sh[b] : sign_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of process ordering.
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: if (data_req && dmem.data_addr_ok_i) state_d = S_WAIT;
      S_WAIT: begin
        if (dmem.data_data_ok_i) begin
          if (flush_i || wb_allowin_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            buf_d   = load_ext;
          end
        end else if (flush_i) begin
          state_d = S_CANCEL;
        end
      end
      S_HOLD:   if (flush_i || wb_allowin_i) state_d = S_IDLE;
      S_CANCEL: if (dmem.data_data_ok_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Non-memory and misaligned instructions complete in IDLE without a request.
  always_comb begin
    ready_go = 1'b0;
    data_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_go = ~aligned_access;
        data_req = mem_valid_i & aligned_access & ~flush_i;
      end
      S_WAIT:  ready_go = dmem.data_data_ok_i;
      S_HOLD:  ready_go = 1'b1;
      default: ready_go = 1'b0;
    endcase
  end

  assign result = (state_q == S_HOLD) ? buf_q : load_ext;

  assign mem_allowin_o     = (state_q != S_CANCEL) &
                             (~mem_valid_i | (ready_go & wb_allowin_i));
  assign mem_to_wb_valid_o = mem_valid_i & ready_go & ~flush_i;

  assign dmem.data_req_o   = data_req;
  assign dmem.data_wr_o    = mem_valid_i & req_i & we_i;
  assign dmem.data_wstrb_o = (mem_valid_i & req_i) ? (size_mask << offset) : '0;
  assign dmem.data_addr_o  = addr_i;
  assign dmem.data_wdata_o = wdata_rep;

  assign ale_o        = mem_to_wb_valid_o & req_i & misaligned;
  assign regs_we_o    = regs_we_i & ~ale_o;
  assign regs_waddr_o = regs_waddr_i;
  assign regs_wdata_o = (aligned_access & ~we_i) ? result : regs_wdata_i;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Randomised bench for mem_lsu_stage (64-bit datapath): a driver issues
// instructions, a slave model serves the data bus, a monitor scores results.
module tb_mem_lsu_stage;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          mem_valid_i, wb_allowin_i, flush_i;
  logic          mem_allowin_o, mem_to_wb_valid_o;
  logic          req_i, we_i, sign_i;
  logic [1:0]    size_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          regs_we_i;
  logic [RW-1:0] regs_waddr_i;
  logic [DW-1:0] regs_wdata_i;
  logic          regs_we_o;
  logic [RW-1:0] regs_waddr_o;
  logic [DW-1:0] regs_wdata_o;
  logic          ale_o;

  mem_lsu_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_lsu_stage #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .wb_allowin_i(wb_allowin_i), .flush_i(flush_i),
    .mem_allowin_o(mem_allowin_o), .mem_to_wb_valid_o(mem_to_wb_valid_o),
    .req_i(req_i), .we_i(we_i), .size_i(size_i), .sign_i(sign_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .regs_we_i(regs_we_i), .regs_waddr_i(regs_waddr_i), .regs_wdata_i(regs_wdata_i),
    .dmem(bus),
    .regs_we_o(regs_we_o), .regs_waddr_o(regs_waddr_o), .regs_wdata_o(regs_wdata_o),
    .ale_o(ale_o)
  );

  typedef struct {
    logic req, we, sign;
    logic [1:0] size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic rwe;
    logic [RW-1:0] waddr;
    logic [DW-1:0] rwdata;
    logic [DW-1:0] rdata;
    int aok, dok, wbm, hold, fl;
  } ins_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic wr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int aok, dok;
  } acc_t;

  typedef struct {
    logic we;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic ale;
  } exp_t;

  acc_t acc_q[$];
  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic mis_of(input logic [1:0] size, input logic [AW-1:0] addr);
    int nb = 1 << size;
    return ((addr % nb) != 0) || (size == 2'd3 && DW == 32);
  endfunction

  function automatic logic [SW-1:0] strb_of(input logic [1:0] size, input logic [AW-1:0] addr);
    logic [127:0] s;
    s = ((128'd1 << (1 << size)) - 128'd1) << (addr % SW);
    return s[SW-1:0];
  endfunction

  function automatic logic [DW-1:0] rep_of(input logic [1:0] size, input logic [DW-1:0] wd);
    logic [127:0] m, v;
    int nbits = 8 << size;
    m = (128'd1 << nbits) - 128'd1;
    v = '0;
    for (int k = 0; k * nbits < DW; k++) v = v | ((128'(wd) & m) << (k * nbits));
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] load_of(input logic [DW-1:0] rdata, input logic [1:0] size,
                                            input logic sign, input logic [AW-1:0] addr);
    logic [127:0] m, v;
    int nbits = 8 << size;
    v = 128'(rdata) >> (8 * (addr % SW));
    m = (128'd1 << nbits) - 128'd1;
    v = v & m;
    if (sign && v[nbits-1]) v = v | ~m;
    return v[DW-1:0];
  endfunction

  function automatic ins_t mk(input logic req, input logic we, input logic [1:0] size,
                              input logic sign, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic rwe, input logic [DW-1:0] rdata, input int aok,
                              input int dok, input int wbm, input int hold, input int fl);
    ins_t t;
    t.req = req; t.we = we; t.size = size; t.sign = sign; t.addr = addr; t.wdata = wdata;
    t.rwe = rwe; t.waddr = RW'($urandom); t.rwdata = {$urandom, $urandom}; t.rdata = rdata;
    t.aok = aok; t.dok = dok; t.wbm = wbm; t.hold = hold; t.fl = fl;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    logic [1:0] size = 2'($urandom_range(0, 3));
    logic [AW-1:0] addr = $urandom;
    int aok = $urandom_range(0, 3);
    int dok = $urandom_range(1, 4);
    int fl = -1;
    if ($urandom_range(0, 3) != 0) addr = addr & ~AW'((1 << size) - 1);
    t = mk($urandom_range(0, 3) != 0, 1'($urandom), size, 1'($urandom), addr,
           {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, aok, dok,
           $urandom_range(0, 2), $urandom_range(0, 3), -1);
    if ($urandom_range(0, 7) == 0) begin
      if (t.req && !mis_of(size, addr)) begin
        case ($urandom_range(0, 3))
          0: fl = 0;
          1: fl = (dok >= 2) ? aok + 1 : aok + dok;
          2: fl = aok + dok;
          default: fl = aok + dok + 1;
        endcase
      end else fl = 0;
    end
    t.fl = fl;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic run_ins(input ins_t t);
    logic mis;
    bit issues;
    int c, lat_exp, cancel, cancel_exp;
    acc_t a;
    exp_t e;
    mis = mis_of(t.size, t.addr);
    issues = t.req && !mis && (t.fl != 0);
    lat_exp = issues ? t.aok + t.dok : 0;
    if (issues) begin
      a.addr = t.addr; a.wr = t.we; a.strb = strb_of(t.size, t.addr);
      a.wdata = rep_of(t.size, t.wdata); a.rdata = t.rdata; a.aok = t.aok; a.dok = t.dok;
      acc_q.push_back(a);
    end
    if (t.fl < 0) begin
      e.ale = t.req && mis;
      e.we = t.rwe && !e.ale;
      e.waddr = t.waddr;
      e.wdata = (t.req && !t.we && !mis) ? load_of(t.rdata, t.size, t.sign, t.addr) : t.rwdata;
      exp_q.push_back(e);
    end
    c = 0;
    forever begin
      mem_valid_i = 1'b1; req_i = t.req; we_i = t.we; size_i = t.size; sign_i = t.sign;
      addr_i = t.addr; wdata_i = t.wdata; regs_we_i = t.rwe; regs_waddr_i = t.waddr;
      regs_wdata_i = t.rwdata; flush_i = (c == t.fl);
      case (t.wbm)
        0: wb_allowin_i = 1'b1;
        1: wb_allowin_i = 1'($urandom);
        default: wb_allowin_i = !(c >= lat_exp && c < lat_exp + t.hold);
      endcase
      if (t.fl >= 0) wb_allowin_i = 1'b0;
      @(negedge clk);
      if (flush_i) begin
        check("flush_valid", mem_to_wb_valid_o, 1'b0);
        break;
      end
      if (t.wbm == 2 && t.fl < 0 && issues && c >= lat_exp && !wb_allowin_i)
        check("hold_stall", {mem_to_wb_valid_o, mem_allowin_o}, 2'b10);
      if (mem_allowin_o) begin
        if (t.wbm == 0) check("latency", c, lat_exp);
        break;
      end
      if (c >= 80) begin
        check("ins_timeout", mem_allowin_o, 1'b1);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    if (t.fl >= 0) begin
      mem_valid_i = 1'b0;
      flush_i = 1'b0;
      cancel_exp = (issues && t.fl > t.aok && t.fl < t.aok + t.dok) ? t.aok + t.dok - t.fl : 0;
      cancel = 0;
      forever begin
        @(negedge clk);
        if (mem_allowin_o || cancel >= 40) break;
        cancel++;
        @(posedge clk); #1;
      end
      check("cancel_cycles", cancel, cancel_exp);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- data-bus slave ----------------
  initial begin
    acc_t cur;
    int phase = 0;
    int wait_n = 0;
    bit fresh;
    bus.data_addr_ok_i = 1'b0;
    bus.data_data_ok_i = 1'b0;
    bus.data_rdata_i   = '0;
    forever begin
      @(posedge clk); #2;
      bus.data_addr_ok_i = 1'b0;
      bus.data_data_ok_i = 1'b0;
      bus.data_rdata_i   = {$urandom, $urandom};
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      fresh = 1'b0;
      if (phase == 0 && bus.data_req_o) begin
        check("req_expected", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) begin
          cur = acc_q.pop_front();
          check("req_addr", bus.data_addr_o, cur.addr);
          check("req_wr", bus.data_wr_o, cur.wr);
          check("req_wstrb", bus.data_wstrb_o, cur.strb);
          check("req_wdata", bus.data_wdata_o, cur.wdata);
          wait_n = cur.aok;
          phase = 1;
          fresh = 1'b1;
        end
      end else if (phase == 2) begin
        check("one_outstanding", bus.data_req_o, 1'b0);
        wait_n--;
        if (wait_n <= 0) begin
          bus.data_data_ok_i = 1'b1;
          bus.data_rdata_i = cur.rdata;
          phase = 0;
        end
      end
      if (phase == 1) begin
        if (!fresh)
          check("req_held", {bus.data_req_o, bus.data_addr_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_wdata_o},
                {1'b1, cur.addr, cur.wr, cur.strb, cur.wdata});
        if (wait_n == 0) begin
          bus.data_addr_ok_i = 1'b1;
          phase = 2;
          wait_n = cur.dok;
        end else wait_n--;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_to_wb_valid_o && wb_allowin_i) begin
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("regs_we", regs_we_o, e.we);
          check("regs_waddr", regs_waddr_o, e.waddr);
          check("regs_wdata", regs_wdata_o, e.wdata);
          check("ale", ale_o, e.ale);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    mem_valid_i = 1'b0; wb_allowin_i = 1'b0; flush_i = 1'b0;
    req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sign_i = 1'b0; addr_i = '0; wdata_i = '0;
    regs_we_i = 1'b0; regs_waddr_i = '0; regs_wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_allowin", mem_allowin_o, 1'b1);
    check("rst_valid", mem_to_wb_valid_o, 1'b0);
    check("rst_req", {bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o}, '0);
    check("rst_regs", {regs_we_o, regs_waddr_o, regs_wdata_o, ale_o}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_ins(mk(1, 0, 0, 1, 32'h1003, 64'h0, 1, 64'h0000_0000_8011_2233, 0, 2, 0, 0, -1));
    run_ins(mk(1, 1, 1, 0, 32'h6, 64'hABCD, 1, 64'h0, 0, 1, 0, 0, -1));
    run_ins(mk(1, 0, 2, 0, 32'h2, 64'h0, 1, 64'h0, 0, 1, 0, 0, -1));
    run_ins(mk(1, 0, 3, 1, 32'h10, 64'h0, 1, 64'hF123_4567_89AB_CDEF, 1, 1, 2, 3, -1));
    run_ins(mk(1, 0, 2, 1, 32'h20, 64'h0, 1, 64'h0, 0, 3, 0, 0, 1));
    run_ins(mk(1, 1, 2, 0, 32'h24, 64'h1234_5678, 1, 64'h0, 4, 2, 0, 0, -1));
    run_ins(mk(1, 0, 2, 0, 32'h28, 64'h0, 1, 64'h0, 0, 1, 0, 0, 0));
    run_ins(mk(1, 0, 1, 1, 32'h2A, 64'h0, 1, 64'h0, 1, 2, 0, 0, 3));
    run_ins(mk(1, 0, 0, 0, 32'h33, 64'h0, 1, 64'h0, 0, 1, 0, 0, 2));
    run_ins(mk(1, 0, 3, 0, 32'h4, 64'h0, 1, 64'h0, 0, 1, 0, 0, -1));
    run_ins(mk(1, 0, 1, 0, 32'h6, 64'h0, 1, 64'h8765_0000_0000_0000, 0, 1, 0, 0, -1));
    run_ins(mk(0, 0, 2, 0, 32'h3, 64'h0, 1, 64'h0, 0, 1, 0, 0, -1));

    for (int n = 0; n < 300; n++) run_ins(rand_ins());

    mem_valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("exp_drained", exp_q.size(), 0);
    check("acc_drained", acc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised memory-access pipeline stage between the EX/MEM and MEM/WB latches of the LoongArch-style in-order pipeline. It issues loads and stores to a split-transaction data-SRAM interface (req/addr_ok, then data_ok), waits out variable memory latency, and buffers the returned data when WB stalls. It extracts and extends load data for byte, half, word and dword sizes, generates write strobes, raises an address-misalignment exception, and cancels in-flight accesses on flush.

## Interface
- DATA_W, 32: data/register width; 32 or 64.
- ADDR_W, 32: address width.
- RADDR_W, 5: register-file write-address width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid_i  in  1  EX/MEM latch holds a valid instruction; inputs stay stable until mem_allowin_o.
- wb_allowin_i  in  1  WB stage accepts data this cycle.
- flush_i  in  1  kill the current instruction and any in-flight access.
- mem_allowin_o  out  1  stage may accept a new instruction.
- mem_to_wb_valid_o  out  1  result valid toward MEM/WB.
- req_i  in  1  instruction accesses memory.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 byte, 1 half, 2 word, 3 dword.
- sign_i  in  1  sign-extend load data.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data, LSB-aligned.
- regs_we_i / regs_waddr_i / regs_wdata_i  in  1 / RADDR_W / DATA_W  register write-back from EX.
- data_req_o  out  1  memory request.
- data_wr_o  out  1  write request.
- data_wstrb_o  out  DATA_W/8  byte strobes.
- data_addr_o  out  ADDR_W  = addr_i.
- data_wdata_o  out  DATA_W  store data replicated to every lane of its size.
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  response (read data or write acknowledge).
- data_rdata_i  in  DATA_W  read data, full bus.
- regs_we_o / regs_waddr_o / regs_wdata_o  out  1 / RADDR_W / DATA_W  to MEM/WB.
- ale_o  out  1  misaligned-address exception, qualified by mem_to_wb_valid_o.

## Operation
- OFF = log2(DATA_W/8) address LSBs. Misaligned when addr_i mod 2^size_i != 0, or size_i=3 with DATA_W=32.
- Strobe = (2^(2^size)-1) << addr[OFF-1:0]. Load result = (rdata >> 8*offset), truncated to 2^size bytes, then sign- or zero-extended to DATA_W.
- regs_wdata_o = extracted load data for loads; otherwise regs_wdata_i. regs_we_o = regs_we_i & !ale_o.
- Non-memory instruction (req_i=0) or misaligned access: no request is issued, ready_go=1 in the same cycle, and ale_o = misaligned.
- FSM states: IDLE, WAIT, HOLD, CANCEL.
  - IDLE: data_req_o = mem_valid_i & req_i & aligned & !flush_i, held until data_addr_ok_i. A handshake (req & addr_ok) moves to WAIT.
  - WAIT: on data_data_ok_i with wb_allowin_i, the result passes through combinationally, ready_go=1, next state IDLE. On data_data_ok_i without wb_allowin_i, the extracted data is latched into the buffer, next state HOLD.
  - HOLD: ready_go=1 and the result comes from the buffer. On wb_allowin_i, next state IDLE.
  - CANCEL: drop the next data_data_ok_i, then go to IDLE. mem_allowin_o=0 and data_req_o=0 while in CANCEL.
- Flush handling:
  - Flush in IDLE: no handshake occurs.
  - Flush in WAIT without data_ok: go to CANCEL.
  - Flush in WAIT with data_ok: discard, go to IDLE.
  - Flush in HOLD: discard buffer, go to IDLE.
  - mem_to_wb_valid_o=0 in any flush cycle.
- mem_allowin_o = (state!=CANCEL) & (!mem_valid_i | (ready_go & wb_allowin_i)).
- mem_to_wb_valid_o = mem_valid_i & ready_go & !flush_i.
- Stores complete on data_data_ok_i the same way as loads; regs_wdata_o = regs_wdata_i for stores.

## Timing
- Reset (asynchronous): state=IDLE, buffer=0. With mem_valid_i=0, all outputs are 0 except mem_allowin_o=1.
- Only one outstanding access; no new request is issued before the previous data_ok.
- Minimum load latency: request cycle N (addr_ok in N), data_ok in N+1, result valid in N+1 when WB allows.
- data_req_o and data_addr_o/data_wdata_o/data_wstrb_o/data_wr_o stay stable from assertion until addr_ok.
- addr_ok and data_ok arriving in the same cycle for the same request are not legal; the slave returns data_ok no earlier than the cycle after addr_ok.
- Reset mid-access returns to IDLE; a stale data_ok after reset is ignored (IDLE treats data_ok as don't-care).

## Test plan
- DATA_W=32, ld.b sign, addr=0x1003, rdata=0x80112233, addr_ok cycle 0, data_ok cycle 2, wb_allowin=1 -> data_wstrb=4'b1000, regs_wdata_o=0xFFFFFF80 with valid in cycle 2 only.
- DATA_W=64, st.h addr=0x6, wdata=0xABCD -> data_wstrb=8'b1100_0000, data_wdata=0xABCDABCDABCDABCD, valid on data_ok, regs_we_o=regs_we_i.
- ld.w addr=0x2, regs_we_i=1 -> data_req_o never asserted, mem_to_wb_valid_o=1 same cycle, ale_o=1, regs_we_o=0.
- Load with data_ok while wb_allowin=0 for 3 cycles -> state HOLD, regs_wdata_o stable from buffer, mem_allowin_o=0, single valid transfer when wb_allowin rises.
- flush_i in WAIT, data_ok 2 cycles later -> CANCEL, mem_allowin_o=0 until data_ok, data discarded, no mem_to_wb_valid_o, next instruction issues the following cycle.
- data_addr_ok_i held 0 for 4 cycles -> data_req_o and address/data held constant, then exactly one handshake.
